// File: rtl/spi_slave_core.sv
// -----------------------------------------------------------------------------
// spi_slave_core
//
// SPI mode-0 slave (CPOL=0, CPHA=0, MSB first). The SPI pins are sampled with
// the system clock through synchronizer chains. The slave shifts a parallel
// transmit word out on miso and shifts a receive word in from mosi. Each
// completed receive word appears on d together with a one-clk finished pulse.
//
// Parameters
//   DATA_W       transfer word width in bits (2 or more)
//   SYNC_STAGES  synchronizer flops per SPI input (2 or more)
//
// Ports
//   clk       in   system clock, rising-edge active
//   reset     in   asynchronous active-low reset
//   sck       in   SPI clock from the master (asynchronous, idles low)
//   ss        in   slave select, active-low (asynchronous)
//   mosi      in   master-out serial data (asynchronous)
//   q         in   [DATA_W] word to transmit; sampled at the start of each word
//   miso      out  slave-out serial data, registered
//   d         out  [DATA_W] last fully received word
//   finished  out  one-clk pulse when a word completes
// -----------------------------------------------------------------------------
module spi_slave_core #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sck,
    input  logic              ss,
    input  logic              mosi,
    input  logic [DATA_W-1:0] q,
    output logic              miso,
    output logic [DATA_W-1:0] d,
    output logic              finished
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] ss_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sck_prev_q;
    logic [DATA_W-1:0]      tx_q, tx_d;
    logic [DATA_W-1:0]      rx_q, rx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]      d_q, d_d;
    logic                   miso_q, miso_d;
    logic                   finished_q, finished_d;

    logic                   sck_s, ss_s, mosi_s;
    logic                   sck_rise, sck_fall;
    logic [DATA_W-1:0]      rx_shifted;

    // Synchronizers and the previous-sck flop used for edge detection.
    // ss resets high so an idle bus is not mistaken for a selection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sck_sync_q  <= '0;
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
        end
    end

    assign sck_s      = sck_sync_q[SYNC_STAGES-1];
    assign ss_s       = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise   = sck_s & ~sck_prev_q;
    assign sck_fall   = ~sck_s & sck_prev_q;
    assign rx_shifted = {rx_q[DATA_W-2:0], mosi_s};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            tx_q       <= '0;
            rx_q       <= '0;
            cnt_q      <= '0;
            d_q        <= '0;
            miso_q     <= 1'b0;
            finished_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            cnt_q      <= cnt_d;
            d_q        <= d_d;
            miso_q     <= miso_d;
            finished_q <= finished_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        cnt_d      = cnt_q;
        d_d        = d_q;
        miso_d     = miso_q;
        finished_d = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                rx_d   = '0;
                miso_d = 1'b0;
                if (!ss_s) begin
                    state_d = LOAD;
                end
            end

            LOAD: begin
                if (ss_s) begin
                    state_d = IDLE;
                    miso_d  = 1'b0;
                end else begin
                    tx_d    = q;
                    miso_d  = q[DATA_W-1];
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                if (ss_s) begin
                    // Deselect mid-word: drop the partial word, d untouched.
                    state_d = IDLE;
                    cnt_d   = '0;
                    rx_d    = '0;
                    miso_d  = 1'b0;
                end else if (sck_rise) begin
                    rx_d = rx_shifted;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        d_d        = rx_shifted;
                        finished_d = 1'b1;
                        cnt_d      = '0;
                        state_d    = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (sck_fall && cnt_q != '0) begin
                    // A fall with the counter at zero is the trailing edge of
                    // the previous word (or precedes the first rise); the
                    // freshly loaded MSB must stay on miso until the next rise.
                    tx_d   = {tx_q[DATA_W-2:0], 1'b0};
                    miso_d = tx_q[DATA_W-2];
                end
            end

            DONE: begin
                cnt_d = '0;
                if (ss_s) begin
                    state_d = IDLE;
                    miso_d  = 1'b0;
                end else begin
                    tx_d    = q;
                    miso_d  = q[DATA_W-1];
                    state_d = SHIFT;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign miso     = miso_q;
    assign d        = d_q;
    assign finished = finished_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_core
//
// Bench for spi_slave_core with an SPI mode-0 master driver. The reference
// model is word-level: every word the master sends completely inside one
// select window is queued, and each finished pulse must deliver the oldest
// queued word on d. miso is compared bit by bit at each sck rise against the
// transmit word that was on q when that word started.
// -----------------------------------------------------------------------------
module tb_spi_slave_core;

    localparam int DATA_W      = 8;
    localparam int SYNC_STAGES = 2;

    logic              clk;
    logic              reset;
    logic              sck;
    logic              ss;
    logic              mosi;
    logic [DATA_W-1:0] q;
    logic              miso;
    logic [DATA_W-1:0] d;
    logic              finished;

    int                checks;
    int                errors;
    int                fin_cnt;
    int                fin_before;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] model_d;
    logic [DATA_W-1:0] tx_words[2];
    logic [DATA_W-1:0] q_words[2];

    spi_slave_core #(
        .DATA_W     (DATA_W),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .sck     (sck),
        .ss      (ss),
        .mosi    (mosi),
        .q       (q),
        .miso    (miso),
        .d       (d),
        .finished(finished)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Each finished pulse must deliver the oldest complete word from the master.
    always @(negedge clk) begin
        if (reset && finished) begin
            fin_cnt++;
            if (exp_q.size() > 0) begin
                model_d = exp_q.pop_front();
                chk("d_word", {24'd0, d}, {24'd0, model_d});
            end else begin
                chk("finished_unexpected", {31'd0, finished}, 32'd0);
            end
        end
    end

    // One select window: nwords words, the last one cut to last_bits bits.
    // sck period 100 ns; all changes land on clk falling edges.
    task automatic spi_frame(input int nwords, input int last_bits);
        int nb;
        q = q_words[0];
        #20 ss = 1'b0;
        #100;
        for (int w = 0; w < nwords; w++) begin
            nb = (w == nwords - 1) ? last_bits : DATA_W;
            for (int b = 0; b < nb; b++) begin
                mosi = tx_words[w][DATA_W-1-b];
                #50;
                if (b == DATA_W - 1) exp_q.push_back(tx_words[w]);
                sck = 1'b1;
                chk("miso_bit", {31'd0, miso}, {31'd0, q_words[w][DATA_W-1-b]});
                if (b == 3 && w + 1 < nwords) q = q_words[w + 1];
                #50 sck = 1'b0;
            end
        end
        #100 ss = 1'b1;
        #100;
        chk("miso_after_ss", {31'd0, miso}, 32'd0);
        chk("pending_words", exp_q.size(), 32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int nw;
        int lb;
        int exp_fin;
        checks  = 0;
        errors  = 0;
        fin_cnt = 0;
        model_d = '0;
        reset   = 1'b0;
        sck     = 1'b0;
        ss      = 1'b1;
        mosi    = 1'b0;
        q       = '0;
        repeat (3) @(negedge clk);
        chk("reset_d", {24'd0, d}, 32'd0);
        chk("reset_finished", {31'd0, finished}, 32'd0);
        chk("reset_miso", {31'd0, miso}, 32'd0);
        reset = 1'b1;
        #40;

        // Single word: q=0x41, master sends 0xF2.
        tx_words[0] = 8'hF2; q_words[0] = 8'h41;
        fin_before = fin_cnt;
        spi_frame(1, DATA_W);
        chk("single_fin_cnt", fin_cnt - fin_before, 32'd1);
        chk("single_d", {24'd0, d}, 32'hF2);

        // Second transfer with all-zero data.
        tx_words[0] = 8'h00; q_words[0] = 8'h41;
        fin_before = fin_cnt;
        spi_frame(1, DATA_W);
        chk("zero_fin_cnt", fin_cnt - fin_before, 32'd1);
        chk("zero_d", {24'd0, d}, 32'h00);

        // Back-to-back words with a q reload for the second one.
        tx_words[0] = 8'hA5; q_words[0] = 8'h41;
        tx_words[1] = 8'h3C; q_words[1] = 8'h96;
        fin_before = fin_cnt;
        spi_frame(2, DATA_W);
        chk("b2b_fin_cnt", fin_cnt - fin_before, 32'd2);
        chk("b2b_d", {24'd0, d}, 32'h3C);

        // Abort after 5 bits, then a full transfer.
        tx_words[0] = 8'h77; q_words[0] = 8'hE1;
        fin_before = fin_cnt;
        spi_frame(1, 5);
        chk("abort_fin_cnt", fin_cnt - fin_before, 32'd0);
        chk("abort_d_kept", {24'd0, d}, 32'h3C);
        tx_words[0] = 8'h5A; q_words[0] = 8'hC3;
        fin_before = fin_cnt;
        spi_frame(1, DATA_W);
        chk("post_abort_fin_cnt", fin_cnt - fin_before, 32'd1);
        chk("post_abort_d", {24'd0, d}, 32'h5A);

        // sck noise with ss high.
        fin_before = fin_cnt;
        for (int i = 0; i < 10; i++) begin
            mosi = 1'($urandom);
            sck  = 1'b1;
            #50;
            chk("noise_miso", {31'd0, miso}, 32'd0);
            sck = 1'b0;
            #50;
        end
        chk("noise_fin_cnt", fin_cnt - fin_before, 32'd0);
        chk("noise_d", {24'd0, d}, {24'd0, model_d});

        // Reset in the middle of the run.
        reset = 1'b0;
        #30;
        reset = 1'b1;
        model_d = '0;
        #20;
        chk("midreset_d", {24'd0, d}, 32'd0);
        chk("midreset_finished", {31'd0, finished}, 32'd0);
        chk("midreset_miso", {31'd0, miso}, 32'd0);

        // Randomized frames, some aborted.
        for (int n = 0; n < 10; n++) begin
            nw = $urandom_range(1, 2);
            for (int w = 0; w < 2; w++) begin
                tx_words[w] = DATA_W'($urandom);
                q_words[w]  = DATA_W'($urandom);
            end
            lb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, DATA_W - 1) : DATA_W;
            exp_fin = (nw - 1) + ((lb == DATA_W) ? 1 : 0);
            fin_before = fin_cnt;
            spi_frame(nw, lb);
            chk("rand_fin_cnt", fin_cnt - fin_before, exp_fin);
            chk("rand_d", {24'd0, d}, {24'd0, model_d});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_core.md
# spi_slave_core

SPI slave endpoint (mode 0: CPOL=0, CPHA=0, MSB first) that sits between an external SPI master and the system clock domain. It oversamples the asynchronous SPI pins with the system clock and shifts a parallel transmit byte out on `miso` while shifting a receive byte in from `mosi`. It presents each completed receive byte on a parallel output with a one-cycle completion strobe.

## Interface
- `DATA_W`, default 8: transfer word width in bits.
- `SYNC_STAGES`, default 2: synchronizer flops on each SPI input, minimum 2.

Ports:
- `clk`  input  1  system clock; all logic is on its rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `sck`  input  1  SPI clock from master, asynchronous, idles low.
- `ss`  input  1  slave select, active-low, asynchronous.
- `mosi`  input  1  master-out data, asynchronous.
- `q`  input  DATA_W  byte to transmit; captured at the start of each word.
- `miso`  output  1  slave-out data, MSB first.
- `d`  output  DATA_W  last fully received word.
- `finished`  output  1  one-`clk` pulse when a word completes.

## Operation
- Synchronization:
  - `sck`, `ss` and `mosi` each pass through `SYNC_STAGES` flops.
  - Edge detection on synchronized `sck` (previous vs current) produces `sck_rise` and `sck_fall` one-cycle pulses.
- States:
  - IDLE: `ss` high. Bit counter is 0 and `miso` is 0.
  - LOAD: on synchronized `ss` falling, the TX shift register takes `q` and `miso` drives `q[DATA_W-1]`.
  - SHIFT: active while `ss` is low.
    - On `sck_rise`: shift synchronized `mosi` into the RX register LSB and increment the bit counter.
    - On `sck_fall`: shift the TX register left so `miso` presents the next bit.
  - DONE: entered when the counter reaches `DATA_W` on an `sck_rise`.
    - `d` takes the complete RX word, including the bit just sampled.
    - `finished` pulses high for 1 `clk`.
    - The counter clears and the TX register reloads from `q`.
    - Returns to SHIFT if `ss` is still low, supporting back-to-back words; otherwise to IDLE.
- `ss` deasserted (synchronized high) in any state: go to IDLE immediately.
  - A partial word is discarded; `d` is unchanged and there is no `finished`.
  - `miso` goes to 0.
- `sck` edges while `ss` is high are ignored.
- `miso` is a plain driven output (no tri-state) and is registered.
- Reset (`reset`=0): state IDLE, `d`=0, `finished`=0, `miso`=0, shift registers and counter cleared. This holds regardless of any transfer in progress.

## Timing
- The master must change `mosi` on `sck` falling edges. The slave samples on `sck` rising edges.
- `sck` high and low phases must each be at least `SYNC_STAGES`+2 `clk` periods.
- `ss` falling must lead the first `sck` rise by at least `SYNC_STAGES`+2 `clk` periods.
- Input-to-action latency is `SYNC_STAGES`+1 `clk` cycles from a pin edge to the internal action.
- `finished` and the new `d` value appear together, `SYNC_STAGES`+1 to `SYNC_STAGES`+2 cycles after the 8th `sck` rising edge. `d` holds until the next completed word.
- `miso` first bit: valid within `SYNC_STAGES`+2 cycles of `ss` falling. Later bits: valid within the same latency after each `sck` fall.
- `q` is sampled only at LOAD/DONE reload; it may change freely at other times.

## Test plan
- Reset: assert `reset`=0 mid-simulation, then release → `d`=0x00, `finished`=0, `miso`=0.
- Single word (`clk` 10 ns, `sck` period 100 ns, `q`=0x41, master sends 0xF2):
  - `miso` bit sequence is 0,1,0,0,0,0,0,1.
  - `d`=0xF2 with one `finished` pulse.
  - `ss` then deasserts.
- Second transfer with master sending 0x00 → `d`=0x00, `finished` pulses once, `miso` again outputs 0x41.
- Back-to-back: 16 `sck` cycles in one `ss` low window, master sends 0xA5 then 0x3C → two `finished` pulses, with `d`=0xA5 then `d`=0x3C. `q` is reloaded for the second word.
- Abort: deassert `ss` after 5 `sck` cycles → no `finished`, `d` keeps its previous value. The next full transfer receives correctly.
- Idle noise: toggle `sck` with `ss` high → no `finished`, `d` unchanged, `miso`=0.
